// File: rtl/regfile_dump.sv
// regfile_dump: walks register indices 0..NREGS-1 through a spare regfile
// read port and streams each {index, value} pair over a valid/ready port.
// The engine only reads the register file; it never writes it.
module regfile_dump #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rf_ra,
   input  logic [DW-1:0] rf_rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_idx,
   output logic [DW-1:0] out_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] rf_ra_q, rf_ra_d;
   logic [AW-1:0] out_idx_q, out_idx_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;

   // Next-state and datapath: one read cycle then one send cycle per register.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_idx_d   = out_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (abort) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               // rf_ra_q already equals idx_q, so rf_rd is this index's value.
               out_data_d  = rf_rd;
               out_idx_d   = idx_q;
               out_valid_d = 1'b1;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            if (abort) begin
               // A pair handshaking in the same cycle is dropped as well.
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = S_READ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase

      // The read address tracks idx while a dump is active and parks at 0
      // otherwise, so the READ cycle always sees a settled address.
      if ((state_d == S_READ) || (state_d == S_SEND)) begin
         rf_ra_d = idx_d;
      end else begin
         rf_ra_d = '0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         rf_ra_q     <= '0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rf_ra_q     <= rf_ra_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = (state_q == S_READ) || (state_q == S_SEND);
   assign done      = (state_q == S_DONE);
   assign rf_ra     = rf_ra_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file.
module tb_regfile_dump;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [4:0]  rf_ra;
   logic [31:0] rf_rd;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_idx;
   logic [31:0] out_data;

   logic [31:0] rf [0:31];

   int checks;
   int errors;

   // results gathered by collect()
   logic [4:0]  p_idx  [0:63];
   logic [31:0] p_data [0:63];
   int          n_pairs;
   int          n_done;
   int          done_iter;
   int          first_valid_iter;
   int          stall_errs;
   logic        busy0;
   logic        post_busy;
   logic        post_done;

   regfile_dump #(.NREGS(32), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .rf_ra     (rf_ra),
      .rf_rd     (rf_rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register 0 is hard-wired to zero
   assign rf_rd = (rf_ra == 5'd0) ? 32'd0 : rf[rf_ra];

   task automatic preload();
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
   endtask

   function automatic logic [31:0] exp_val(input int i);
      return (i == 0) ? 32'd0 : (32'h1000_0000 + i);
   endfunction

   // Called at the negedge after the start edge E0 (iteration n = state after E_n).
   // Records accepted pairs, done pulses and stall-stability violations.
   task automatic collect(input int budget, input bit rand_ready,
                          input bit restarts, input bit do_write);
      bit          prev_stall;
      logic [4:0]  prev_idx;
      logic [31:0] prev_data;
      n_pairs = 0; n_done = 0; done_iter = -1; first_valid_iter = -1;
      stall_errs = 0; prev_stall = 0; prev_idx = '0; prev_data = '0;
      busy0 = busy; post_busy = 1'b1; post_done = 1'b1;
      for (int n = 0; n < budget; n++) begin
         if (prev_stall && (!out_valid || out_idx !== prev_idx || out_data !== prev_data))
            stall_errs++;
         if (out_valid && first_valid_iter < 0) first_valid_iter = n;
         if (done === 1'b1) begin
            n_done++;
            if (done_iter < 0) done_iter = n;
         end
         if (done_iter >= 0 && n == done_iter + 1) begin
            post_busy = busy;
            post_done = done;
            break;
         end
         if (do_write && n == 10) begin
            rf[20] = 32'hDEAD_BEEF;
            rf[3]  = 32'hCAFE_F00D;
         end
         start     = restarts && (n == 10 || n == 40);
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            if (n_pairs < 64) begin
               p_idx[n_pairs]  = out_idx;
               p_data[n_pairs] = out_data;
            end
            n_pairs++;
         end
         prev_stall = out_valid && !out_ready;
         prev_idx   = out_idx;
         prev_data  = out_data;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      preload();
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (rf_ra !== 5'd0) begin errors++; $display("FAIL reset_rf_ra got %0d want 0", rf_ra); end
      checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_dump();
      preload();
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      checks++; if (rf_ra !== 5'd0) begin errors++; $display("FAIL full_rf_ra_e0 got %0d want 0", rf_ra); end
      collect(200, 1'b0, 1'b0, 1'b0);
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL full_busy_e0 got %b want 1", busy0); end
      checks++; if (first_valid_iter != 1) begin errors++; $display("FAIL full_first_valid got %0d want 1", first_valid_iter); end
      checks++; if (n_pairs != 32) begin errors++; $display("FAIL full_pairs got %0d want 32", n_pairs); end
      for (int i = 0; i < 32 && i < n_pairs; i++) begin
         checks++;
         if (p_idx[i] !== 5'(i) || p_data[i] !== exp_val(i)) begin
            errors++;
            $display("FAIL full_pair%0d got (%0d,%h) want (%0d,%h)", i, p_idx[i], p_data[i], i, exp_val(i));
         end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL full_done_count got %0d want 1", n_done); end
      checks++; if (done_iter != 64) begin errors++; $display("FAIL full_done_cycle got %0d want 64", done_iter); end
      checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL full_after_done busy=%b done=%b want 0 0", post_busy, post_done); end
   endtask

   task automatic test_backpressure();
      preload();
      out_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      collect(400, 1'b1, 1'b0, 1'b0);
      checks++; if (n_pairs != 32) begin errors++; $display("FAIL bp_pairs got %0d want 32", n_pairs); end
      for (int i = 0; i < 32 && i < n_pairs; i++) begin
         checks++;
         if (p_idx[i] !== 5'(i) || p_data[i] !== exp_val(i)) begin
            errors++;
            $display("FAIL bp_pair%0d got (%0d,%h) want (%0d,%h)", i, p_idx[i], p_data[i], i, exp_val(i));
         end
      end
      checks++; if (stall_errs != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_errs); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", n_done); end
   endtask

   task automatic test_restart_ignored();
      preload();
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      collect(200, 1'b0, 1'b1, 1'b0);
      checks++; if (n_pairs != 32) begin errors++; $display("FAIL restart_pairs got %0d want 32", n_pairs); end
      checks++; if (n_pairs > 31 && p_idx[31] !== 5'd31) begin errors++; $display("FAIL restart_last_idx got %0d want 31", p_idx[31]); end
      checks++; if (done_iter != 64) begin errors++; $display("FAIL restart_done_cycle got %0d want 64", done_iter); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", n_done); end
   endtask

   task automatic test_abort();
      int dones;
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid && out_idx == 5'd7) break;
         @(negedge clk);
      end
      checks++; if (!(out_valid === 1'b1 && out_idx === 5'd7)) begin errors++; $display("FAIL abort_reach_idx7 got valid=%b idx=%0d want 1 7", out_valid, out_idx); end
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         if (done === 1'b1) dones++;
         @(negedge clk);
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
      start = 1'b1;
      @(negedge clk);
      collect(200, 1'b0, 1'b0, 1'b0);
      checks++; if (n_pairs != 32 || p_idx[0] !== 5'd0) begin errors++; $display("FAIL abort_redump pairs=%0d first=%0d want 32 0", n_pairs, p_idx[0]); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL abort_redump_done got %0d want 1", n_done); end
   endtask

   task automatic test_reset_mid();
      int dones;
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid && out_idx == 5'd12) break;
         @(negedge clk);
      end
      checks++; if (!(out_valid === 1'b1 && out_idx === 5'd12)) begin errors++; $display("FAIL rstmid_reach_idx12 got valid=%b idx=%0d want 1 12", out_valid, out_idx); end
      rst_n = 1'b0;
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rf_ra !== 5'd0 ||
          out_idx !== 5'd0 || out_data !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got busy=%b done=%b valid=%b ra=%0d idx=%0d data=%h want all 0",
                  busy, done, out_valid, rf_ra, out_idx, out_data);
      end
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         if (done === 1'b1 || busy === 1'b1) dones++;
         @(negedge clk);
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_idle got %0d active cycles want 0", dones); end
      start = 1'b1;
      @(negedge clk);
      collect(200, 1'b0, 1'b0, 1'b0);
      checks++; if (n_pairs != 32 || n_done != 1) begin errors++; $display("FAIL rstmid_redump pairs=%0d dones=%0d want 32 1", n_pairs, n_done); end
   endtask

   task automatic test_write_window();
      preload();
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      collect(200, 1'b0, 1'b0, 1'b1);
      checks++; if (n_pairs != 32) begin errors++; $display("FAIL write_pairs got %0d want 32", n_pairs); end
      checks++; if (p_data[20] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_pair20 got %h want deadbeef", p_data[20]); end
      checks++; if (p_data[3] !== 32'h1000_0003) begin errors++; $display("FAIL write_pair3 got %h want 10000003", p_data[3]); end
      checks++; if (p_data[21] !== 32'h1000_0015) begin errors++; $display("FAIL write_pair21 got %h want 10000015", p_data[21]); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_restart_ignored();
      test_abort();
      test_reset_mid();
      test_write_window();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the MIPS register file. On a start pulse it walks register indices 0..NREGS-1 through a spare regfile read port and streams each {index, value} pair out over a valid/ready interface, e.g. to a UART or trace buffer. It is the reader counterpart to the writeback path and never writes the register file.

## Interface
- NREGS, 32, number of registers dumped (indices 0..NREGS-1)
- AW, 5, register address width; NREGS <= 2**AW
- DW, 32, register data width
- clk  input  1  single clock, all state on posedge
- rst_n  input  1  synchronous, active-low reset; sampled on posedge clk
- start  input  1  begin a dump; honoured only in IDLE
- abort  input  1  cancel an in-progress dump
- busy  output  1  high in READ or SEND
- done  output  1  one-cycle pulse after the last pair is accepted
- rf_ra  output  AW  read address to the regfile port
- rf_rd  input  DW  combinational read data for rf_ra (register 0 reads 0)
- out_valid  output  1  out_idx/out_data hold a pair
- out_ready  input  1  sink accepts the pair when out_valid && out_ready
- out_idx  output  AW  register index of the current pair
- out_data  output  DW  register value of the current pair

## Operation
- Reset (rst_n=0 at an edge): state IDLE; idx, rf_ra, out_idx, out_data = 0; out_valid, busy, done = 0.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: if start, set idx=0 and go to READ. Otherwise stay.
- READ: rf_ra=idx. At the edge, capture out_data<=rf_rd and out_idx<=idx, set out_valid=1, and go to SEND.
- SEND: out_valid, out_idx and out_data are held stable until a handshake occurs.
  - On a handshake: out_valid<=0. If idx==NREGS-1, go to DONE. Else idx<=idx+1 and go to READ.
- DONE: done=1 for exactly this cycle, then IDLE.
- rf_ra is a register that follows idx. It is 0 in IDLE.
- abort (READ or SEND, any out_ready): go to IDLE next edge, out_valid<=0, done not pulsed. A pending pair is dropped even if handshaking that cycle. abort has priority over start.
- start while busy or in DONE: ignored, no restart.
- idx never exceeds NREGS-1; no wrap-around.
- Values are sampled in the READ cycle, not at start. A regfile write that lands before an index's READ cycle is visible in the dump; later writes are not.
- rst_n low in any state returns to the reset values on that edge, overriding abort and start.

## Timing
- Edge numbering: start sampled at edge E0.
  - After E0: READ, busy=1, rf_ra=0.
  - After E1: out_valid=1, out_idx=0.
- Throughput: 2 cycles per register at best (READ + SEND), with no back-to-back valids.
- With out_ready held high:
  - Pair i is valid in the cycle after E(1+2i) and accepted at E(2+2i).
  - The last pair for NREGS=32 is accepted at E64.
  - done=1 and busy=0 in the cycle after E64; IDLE after E65.
- Backpressure: each cycle of out_ready=0 in SEND adds one cycle.
- Earliest restart: start sampled in the cycle after E65, i.e. the first IDLE cycle.

## Test plan
- Preload r1..r31 = 32'h1000_0000+i. Pulse start with out_ready=1. Expect 32 pairs (0,0), (1,32'h1000_0001) … (31,32'h1000_001F), the first valid 2 cycles after start. Expect a done pulse at cycle 65 and busy=0 afterwards.
- Random out_ready with 50% duty. Expect the same 32 pairs in order, out_idx/out_data stable while valid && !ready, and no dropped or duplicated index.
- Pulse start again at cycles 10 and 40 of a dump. Expect no restart and exactly 32 pairs.
- Assert abort while out_valid=1 at idx=7. Expect out_valid=0 and IDLE next cycle, no done. A fresh start then dumps from idx 0.
- Hold rst_n=0 for one edge during SEND at idx=12. Expect all outputs 0, IDLE, and no done. A subsequent start produces a full 32-pair dump.
- Write r20=32'hDEAD_BEEF while idx=5, and write r3=32'hCAFE_F00D in the same window. Expect pair 20 = DEAD_BEEF and pair 3 = its old value.
